bus_master: RTL and testbench

BUS_MASTER -- requirements
Module: bus_master

---
 rtl/bus_master_pkg.sv | 23 ++
 rtl/bus_master_cmd_fifo.sv | 53 +++++
 rtl/bus_master.sv | 127 ++++++++++++
 tb/tb_bus_master.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_master_pkg.sv
// Shared types for the bus master: FSM state encoding and the command-queue entry.
// The entry struct fixes the address/data widths that bus_master's defaults match.
package bus_master_pkg;

  localparam int CMD_ADDR_W = 8;
  localparam int CMD_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    XFER    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  typedef struct packed {
    logic                  wr;
    logic [CMD_ADDR_W-1:0] addr;
    logic [CMD_DATA_W-1:0] wdata;
  } cmd_t;

  localparam int CMD_W = $bits(cmd_t);

endpackage

// File: rtl/bus_master_cmd_fifo.sv
// Synchronous command queue with first-word fall-through read port.
// DEPTH must be a power of two so the pointers wrap naturally.
module cmd_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/bus_master.sv
// Queued bus master: buffers commands, requests the bus, runs bursts of up to
// MAX_BURST transfers per tenure and returns read data one cycle after m_rd.
module bus_master
  import bus_master_pkg::*;
#(
  parameter int ADDR_W     = CMD_ADDR_W,
  parameter int DATA_W     = CMD_DATA_W,
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_BURST  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_wr,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              m_req,
  input  logic              m_grant,
  output logic              m_wr,
  output logic              m_rd,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_dout,
  input  logic [DATA_W-1:0] m_din,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata
);

  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  state_t        state;
  state_t        next_state;
  logic [BW-1:0] burst_cnt;
  cmd_t          in_cmd;
  cmd_t          head;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic          push;
  logic          pop;
  logic          xfer_go;

  assign in_cmd    = '{wr: cmd_wr, addr: cmd_addr, wdata: cmd_wdata};
  assign cmd_ready = !fifo_full;
  assign push      = cmd_valid && cmd_ready;
  assign xfer_go   = (state == XFER) && m_grant && !fifo_empty;

  cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (in_cmd),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // A tenure ends when the burst cap is hit or the queue drains without a refill.
  always_comb begin
    next_state = state;
    m_req      = 1'b0;
    m_wr       = 1'b0;
    m_rd       = 1'b0;
    m_addr     = '0;
    m_dout     = '0;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) next_state = REQ;
      end
      REQ: begin
        m_req = 1'b1;
        if (m_grant) next_state = XFER;
      end
      XFER: begin
        m_req = 1'b1;
        if (xfer_go) begin
          pop    = 1'b1;
          m_wr   = head.wr;
          m_rd   = !head.wr;
          m_addr = head.addr;
          m_dout = head.wdata;
          if (burst_cnt == BW'(MAX_BURST - 1) || (fifo_count == CW'(1) && !push))
            next_state = RELEASE;
        end else if (!m_grant) begin
          next_state = REQ;
        end else begin
          next_state = RELEASE;
        end
      end
      RELEASE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      burst_cnt <= '0;
    end else if (state == REQ && m_grant) begin
      burst_cnt <= '0;
    end else if (pop) begin
      burst_cnt <= burst_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= pop && !head.wr;
      if (pop && !head.wr) rsp_rdata <= m_din;
    end
  end

endmodule

// File: tb/tb_bus_master.sv
// Scoreboard bench for bus_master: expected transfers/responses are queued at
// command acceptance and compared against what a negedge monitor observes.
module tb_bus_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_wr;
  logic [7:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        m_req;
  logic        m_grant;
  logic        m_wr;
  logic        m_rd;
  logic [7:0]  m_addr;
  logic [31:0] m_dout;
  logic [31:0] m_din;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;

  typedef struct {
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] data;
    int          cyc;
  } xfer_t;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } rsp_t;

  xfer_t       exp_x[$];
  xfer_t       obs_x[$];
  logic [31:0] exp_r[$];
  rsp_t        obs_r[$];
  int          low_runs[$];
  int          n_checks = 0;
  int          n_fails = 0;
  int          cyc = 0;
  int          low_start = 0;
  int          strobe_clash = 0;
  logic        req_prev = 1'b0;
  logic        req_last = 1'b0;
  bit          auto_grant = 1'b0;

  always #5 clk = ~clk;

  bus_master #(
    .ADDR_W(8), .DATA_W(32), .FIFO_DEPTH(4), .MAX_BURST(4)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .m_req(m_req), .m_grant(m_grant), .m_wr(m_wr), .m_rd(m_rd),
    .m_addr(m_addr), .m_dout(m_dout), .m_din(m_din),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata)
  );

  // Slave model: fixed pattern per address, with the one address the read test uses.
  function automatic logic [31:0] slave_data(input logic [7:0] a);
    return (a == 8'h20) ? 32'h12345678 : {8'hA5, a, ~a, 8'h3C};
  endfunction

  assign m_din = slave_data(m_addr);

  always @(negedge clk) begin
    cyc++;
    req_prev = m_req;
    if (!reset) begin
      if (m_wr || m_rd) obs_x.push_back('{m_wr, m_addr, m_wr ? m_dout : m_din, cyc});
      if (m_wr && m_rd) strobe_clash++;
      if ((m_wr || m_rd) && !m_req) strobe_clash++;
      if (rsp_valid) obs_r.push_back('{rsp_rdata, cyc});
      if (!m_req && req_last) low_start = cyc;
      if (m_req && !req_last && low_start > 0) low_runs.push_back(cyc - low_start);
      req_last = m_req;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (auto_grant) m_grant = req_prev;
  endtask

  task automatic drain(input int n);
    repeat (n) step();
  endtask

  task automatic clear_sb();
    exp_x.delete();
    obs_x.delete();
    exp_r.delete();
    obs_r.delete();
    low_runs.delete();
    low_start = 0;
  endtask

  task automatic push_cmd(input logic wr, input logic [7:0] addr, input logic [31:0] data,
                          output int acc_cyc);
    cmd_valid = 1'b1;
    cmd_wr    = wr;
    cmd_addr  = addr;
    cmd_wdata = data;
    acc_cyc   = -1;
    for (int i = 0; i < 50; i++) begin
      if (cmd_ready) begin
        acc_cyc = cyc + 1;
        exp_x.push_back('{wr, addr, wr ? data : slave_data(addr), 0});
        if (!wr) exp_r.push_back(slave_data(addr));
        step();
        break;
      end
      step();
    end
    cmd_valid = 1'b0;
    if (acc_cyc < 0) begin
      n_checks++;
      n_fails++;
      $display("[TB] FAIL push_timeout: addr %h not accepted within 50 cycles", addr);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_wdata = '0; m_grant = 1'b0;
    drain(3);
    n_checks++;
    if (m_req !== 1'b0) begin n_fails++; $display("[TB] FAIL reset_m_req: got %b want 0", m_req); end
    n_checks++;
    if (rsp_valid !== 1'b0) begin n_fails++; $display("[TB] FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    n_checks++;
    if (rsp_rdata !== 32'h0) begin n_fails++; $display("[TB] FAIL reset_rsp_rdata: got %h want 0", rsp_rdata); end
    n_checks++;
    if ({m_wr, m_rd} !== 2'b00) begin n_fails++; $display("[TB] FAIL reset_strobes: got %b want 00", {m_wr, m_rd}); end
    reset = 1'b0;
    step();
    n_checks++;
    if (cmd_ready !== 1'b1) begin n_fails++; $display("[TB] FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
  endtask

  task automatic test_single_write();
    int acc;
    clear_sb();
    auto_grant = 1'b1;
    push_cmd(1'b1, 8'h10, 32'hDEADBEEF, acc);
    drain(20);
    n_checks++;
    if (obs_x.size() != 1) begin n_fails++; $display("[TB] FAIL wr_count: got %0d transfers want 1", obs_x.size()); end
    for (int i = 0; i < obs_x.size() && i < exp_x.size(); i++) begin
      n_checks++;
      if (obs_x[i].wr !== exp_x[i].wr || obs_x[i].addr !== exp_x[i].addr || obs_x[i].data !== exp_x[i].data) begin
        n_fails++;
        $display("[TB] FAIL wr_xfer: got wr=%b a=%h d=%h want wr=%b a=%h d=%h", obs_x[i].wr, obs_x[i].addr,
                 obs_x[i].data, exp_x[i].wr, exp_x[i].addr, exp_x[i].data);
      end
    end
    n_checks++;
    if (obs_r.size() != 0) begin n_fails++; $display("[TB] FAIL wr_no_rsp: got %0d responses want 0", obs_r.size()); end
    n_checks++;
    if (m_req !== 1'b0) begin n_fails++; $display("[TB] FAIL wr_req_idle: got %b want 0", m_req); end
  endtask

  task automatic test_single_read();
    int acc;
    clear_sb();
    push_cmd(1'b0, 8'h20, 32'h0, acc);
    drain(20);
    n_checks++;
    if (obs_x.size() != 1) begin n_fails++; $display("[TB] FAIL rd_count: got %0d transfers want 1", obs_x.size()); end
    n_checks++;
    if (obs_r.size() != 1) begin n_fails++; $display("[TB] FAIL rd_rsp_count: got %0d want 1", obs_r.size()); end
    if (obs_x.size() == 1 && obs_r.size() == 1) begin
      n_checks++;
      if (obs_x[0].wr !== 1'b0 || obs_x[0].addr !== exp_x[0].addr) begin
        n_fails++; $display("[TB] FAIL rd_xfer: got wr=%b a=%h want wr=0 a=%h", obs_x[0].wr, obs_x[0].addr, exp_x[0].addr);
      end
      n_checks++;
      if (obs_r[0].data !== exp_r[0]) begin
        n_fails++; $display("[TB] FAIL rd_data: got %h want %h", obs_r[0].data, exp_r[0]);
      end
      n_checks++;
      if (obs_r[0].cyc != obs_x[0].cyc + 1) begin
        n_fails++; $display("[TB] FAIL rd_latency: got rsp cycle %0d want %0d", obs_r[0].cyc, obs_x[0].cyc + 1);
      end
    end
  endtask

  task automatic test_burst_cap();
    int acc;
    clear_sb();
    for (int i = 0; i < 6; i++) push_cmd(1'b1, 8'(i), 32'h1000 + 32'(i), acc);
    drain(30);
    n_checks++;
    if (obs_x.size() != 6) begin n_fails++; $display("[TB] FAIL burst_count: got %0d transfers want 6", obs_x.size()); end
    for (int i = 0; i < obs_x.size() && i < exp_x.size(); i++) begin
      n_checks++;
      if (obs_x[i].wr !== 1'b1 || obs_x[i].addr !== exp_x[i].addr || obs_x[i].data !== exp_x[i].data) begin
        n_fails++;
        $display("[TB] FAIL burst_order[%0d]: got a=%h d=%h want a=%h d=%h", i, obs_x[i].addr, obs_x[i].data,
                 exp_x[i].addr, exp_x[i].data);
      end
    end
    if (obs_x.size() == 6) begin
      n_checks++;
      if (obs_x[3].cyc != obs_x[0].cyc + 3 || obs_x[5].cyc != obs_x[4].cyc + 1) begin
        n_fails++; $display("[TB] FAIL burst_b2b: got cycles %0d..%0d and %0d,%0d", obs_x[0].cyc, obs_x[3].cyc,
                            obs_x[4].cyc, obs_x[5].cyc);
      end
      n_checks++;
      if (obs_x[4].cyc <= obs_x[3].cyc + 1) begin
        n_fails++; $display("[TB] FAIL burst_split: got 5th at cycle %0d, 4th at %0d, want a tenure gap", obs_x[4].cyc,
                            obs_x[3].cyc);
      end
    end
    n_checks++;
    if (low_runs.size() != 1 || low_runs[0] < 1 || low_runs[0] > 2) begin
      n_fails++; $display("[TB] FAIL burst_req_drop: got %0d drops (first %0d cycles) want 1 drop of 1-2 cycles",
                          low_runs.size(), (low_runs.size() > 0) ? low_runs[0] : 0);
    end
    n_checks++;
    if (rsp_rdata !== 32'h12345678) begin n_fails++; $display("[TB] FAIL rdata_hold: got %h want 12345678", rsp_rdata); end
  endtask

  task automatic test_full_queue();
    int acc;
    int acc5;
    clear_sb();
    auto_grant = 1'b0;
    m_grant    = 1'b0;
    for (int i = 0; i < 4; i++) push_cmd(1'b1, 8'h40 + 8'(i), 32'hF000 + 32'(i), acc);
    n_checks++;
    if (cmd_ready !== 1'b0) begin n_fails++; $display("[TB] FAIL full_ready: got %b want 0", cmd_ready); end
    cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 8'h44; cmd_wdata = 32'hF004;
    drain(3);
    n_checks++;
    if (cmd_ready !== 1'b0 || obs_x.size() != 0) begin
      n_fails++; $display("[TB] FAIL full_hold: got ready=%b transfers=%0d want ready=0 transfers=0", cmd_ready, obs_x.size());
    end
    auto_grant = 1'b1;
    push_cmd(1'b1, 8'h44, 32'hF004, acc5);
    drain(30);
    n_checks++;
    if (obs_x.size() != 5) begin n_fails++; $display("[TB] FAIL full_count: got %0d transfers want 5", obs_x.size()); end
    if (obs_x.size() > 0) begin
      n_checks++;
      if (acc5 <= obs_x[0].cyc) begin
        n_fails++; $display("[TB] FAIL full_accept: got 5th accepted cycle %0d want after first pop at %0d", acc5, obs_x[0].cyc);
      end
    end
    for (int i = 0; i < obs_x.size() && i < exp_x.size(); i++) begin
      n_checks++;
      if (obs_x[i].addr !== exp_x[i].addr || obs_x[i].data !== exp_x[i].data) begin
        n_fails++; $display("[TB] FAIL full_order[%0d]: got a=%h d=%h want a=%h d=%h", i, obs_x[i].addr, obs_x[i].data,
                            exp_x[i].addr, exp_x[i].data);
      end
    end
  endtask

  task automatic test_grant_loss();
    int acc;
    clear_sb();
    auto_grant = 1'b0;
    m_grant    = 1'b0;
    for (int i = 0; i < 3; i++) push_cmd(1'b0, 8'h30 + 8'(i), 32'h0, acc);
    m_grant = 1'b1;
    step();
    step();
    m_grant = 1'b0;
    #1;
    n_checks++;
    if ({m_wr, m_rd} !== 2'b00 || m_req !== 1'b1) begin
      n_fails++; $display("[TB] FAIL loss_strobe: got wr/rd=%b req=%b want 00 req=1", {m_wr, m_rd}, m_req);
    end
    step();
    m_grant = 1'b1;
    drain(10);
    m_grant = 1'b0;
    drain(3);
    n_checks++;
    if (obs_x.size() != 3) begin n_fails++; $display("[TB] FAIL loss_count: got %0d reads want 3", obs_x.size()); end
    for (int i = 0; i < obs_x.size() && i < exp_x.size(); i++) begin
      n_checks++;
      if (obs_x[i].wr !== 1'b0 || obs_x[i].addr !== exp_x[i].addr) begin
        n_fails++; $display("[TB] FAIL loss_order[%0d]: got wr=%b a=%h want wr=0 a=%h", i, obs_x[i].wr, obs_x[i].addr,
                            exp_x[i].addr);
      end
    end
    n_checks++;
    if (obs_r.size() != 3) begin n_fails++; $display("[TB] FAIL loss_rsp_count: got %0d want 3", obs_r.size()); end
    for (int i = 0; i < obs_r.size() && i < exp_r.size(); i++) begin
      n_checks++;
      if (obs_r[i].data !== exp_r[i]) begin
        n_fails++; $display("[TB] FAIL loss_rsp[%0d]: got %h want %h", i, obs_r[i].data, exp_r[i]);
      end
    end
  endtask

  task automatic test_reset_xfer();
    int acc;
    clear_sb();
    auto_grant = 1'b0;
    m_grant    = 1'b0;
    for (int i = 0; i < 3; i++) push_cmd(1'b0, 8'h50 + 8'(i), 32'h0, acc);
    m_grant = 1'b1;
    step();
    reset = 1'b1;
    step();
    n_checks++;
    if (m_req !== 1'b0) begin n_fails++; $display("[TB] FAIL rstx_m_req: got %b want 0", m_req); end
    n_checks++;
    if (cmd_ready !== 1'b1) begin n_fails++; $display("[TB] FAIL rstx_ready: got %b want 1", cmd_ready); end
    n_checks++;
    if (rsp_valid !== 1'b0) begin n_fails++; $display("[TB] FAIL rstx_rsp: got %b want 0", rsp_valid); end
    reset   = 1'b0;
    m_grant = 1'b0;
    exp_x.delete();
    exp_r.delete();
    drain(10);
    n_checks++;
    if (obs_x.size() != 0 || obs_r.size() != 0 || m_req !== 1'b0) begin
      n_fails++; $display("[TB] FAIL rstx_flushed: got transfers=%0d rsps=%0d req=%b want 0 0 0", obs_x.size(),
                          obs_r.size(), m_req);
    end
  endtask

  task automatic test_protocol();
    n_checks++;
    if (strobe_clash != 0) begin
      n_fails++; $display("[TB] FAIL strobe_rules: got %0d bad strobe cycles want 0", strobe_clash);
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_single_read();
    test_burst_cap();
    test_full_queue();
    test_grant_loss();
    test_reset_xfer();
    test_protocol();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
